// File: rtl/pool_max2x2.sv
// pool_max2x2: 2x2 stride-2 max pooling over one 2x26 bank of a ping-pong conv output buffer.
module pool_max2x2 #(
  parameter int DATA_W     = 8,
  parameter int ROW_LEN    = 26,
  parameter int ADDR_W     = 7,
  parameter int BANK_WORDS = 52
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bank_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pool_out,
  output logic              pool_valid,
  output logic [3:0]        pool_col,
  output logic              bank_free,
  output logic              free_id,
  output logic              busy,
  output logic              overrun
);
  localparam int CW = $clog2(BANK_WORDS + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t            state;
  logic [CW-1:0]     r, d;
  logic              cur, pend, pend_bank, dv, take, nb;
  logic [DATA_W-1:0] acc, mx;
  function automatic logic [ADDR_W-1:0] addr_of(input logic b, input logic [CW-1:0] i);
    addr_of = ADDR_W'(b ? BANK_WORDS : 0) + ADDR_W'({i[CW-1:2], 1'b0}) + ADDR_W'(i[0])
            + (i[1] ? ADDR_W'(ROW_LEN) : '0);
  endfunction
  always_comb begin
    take = (state == IDLE && (pend || start)) || (state == DRAIN && bank_free && pend);
    nb   = pend ? pend_bank : bank_sel;
    mx   = rd_data > acc ? rd_data : acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r          <= '0;
      d          <= '0;
      cur        <= 1'b0;
      pend       <= 1'b0;
      pend_bank  <= 1'b0;
      dv         <= 1'b0;
      acc        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pool_out   <= '0;
      pool_valid <= 1'b0;
      pool_col   <= '0;
      bank_free  <= 1'b0;
      free_id    <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      bank_free  <= 1'b0;
      dv         <= rd_en;
      if (start && !(state == IDLE && !pend)) begin
        if (pend && !take) overrun <= 1'b1;
        else begin
          pend      <= 1'b1;
          pend_bank <= bank_sel;
        end
      end else if (take && pend) pend <= 1'b0;
      if (take) begin
        state   <= READ;
        cur     <= nb;
        rd_en   <= 1'b1;
        rd_addr <= addr_of(nb, '0);
        r       <= CW'(1);
        busy    <= 1'b1;
      end else if (state == READ) begin
        if (r == CW'(BANK_WORDS)) begin
          rd_en <= 1'b0;
          state <= DRAIN;
        end else begin
          rd_addr <= addr_of(cur, r);
          r       <= r + 1'b1;
        end
      end else if (state == DRAIN && bank_free) begin
        state <= IDLE;
        busy  <= start;
      end
      if (dv) begin
        d   <= d == CW'(BANK_WORDS - 1) ? '0 : d + 1'b1;
        acc <= d[1:0] == 2'd0 ? rd_data : mx;
        if (d[1:0] == 2'd3) begin
          pool_valid <= 1'b1;
          pool_out   <= mx;
          pool_col   <= 4'(d[CW-1:2]);
        end
        if (d == CW'(BANK_WORDS - 1)) begin
          bank_free <= 1'b1;
          free_id   <= cur;
        end
      end
    end
  end
endmodule

// File: doc/pool_max2x2.md
Name: pool_max2x2

Overview:
- Downstream consumer of the first conv layer's 4x26 ping-pong output buffer.
- Reads one 2-row bank (2x26 pixels) through the buffer's registered read port.
- Computes 2x2 max-pooling with stride 2, producing 13 pooled pixels per bank.
- Releases the bank back to the conv writer so it can be refilled.

Parameters:
- DATA_W, 8, pixel width (unsigned, post-ReLU).
- ROW_LEN, 26, pixels per conv-output row.
- ADDR_W, 7, buffer address width.
- BANK_WORDS, 52, words per bank (2*ROW_LEN). Bank b occupies base b*BANK_WORDS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request: bank bank_sel is full and ready to pool.
- bank_sel  in  1  bank index for start (0: addr 0..51, 1: addr 52..103).
- rd_en  out  1  buffer read enable.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  DATA_W  buffer output. Valid the cycle after rd_en; reads 0 when rd_en was low.
- pool_out  out  DATA_W  pooled pixel.
- pool_valid  out  1  one-cycle strobe qualifying pool_out/pool_col.
- pool_col  out  4  output column 0..12.
- bank_free  out  1  one-cycle pulse: the bank in free_id may be overwritten.
- free_id  out  1  bank being released.
- busy  out  1  high from the cycle after an accepted start until bank_free.
- overrun  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, pending request is cleared, counters are 0. Reset mid-bank aborts immediately: rd_en drops the next cycle, and no pool_valid or bank_free is produced for the aborted bank.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start, or a pending request, is latched (bank, base) -> READ.
  - READ: one read per cycle for 52 cycles -> DRAIN.
  - DRAIN: waits for the last datum, emits the final result with bank_free -> IDLE, or -> READ directly if a request is pending.
- Read order, window k = 0..12, with base = bank*52: base+2k, base+2k+1, base+26+2k, base+27+2k. Windows are issued back-to-back with no bubbles.
- Timing: let S = first READ cycle (the cycle after start is sampled).
  - rd_en is high for cycles S..S+51.
  - rd_data for window k arrives in cycles S+4k+1..S+4k+4.
  - pool_valid is high in cycle S+4k+5, giving 13 strobes from S+5 to S+53.
- Max datapath:
  - The first datum of each window loads the accumulator.
  - The next three data are unsigned compares; ties keep the existing value.
  - pool_out = max of all four. Width stays DATA_W; no arithmetic growth.
  - pool_col = k.
- bank_free/free_id pulse in the same cycle as the 13th pool_valid (S+53). busy falls in the following cycle unless a pending request starts.
- Start while idle: accepted.
- Start while busy with no pending request: latched as pending (depth 1). It begins READ at cycle S+54 of the current bank, and busy stays high.
- Start while busy with a request already pending: dropped, overrun <= 1.
- Start in the same cycle as bank_free: treated as busy, so it becomes pending.
- rd_addr holds its last value when rd_en is low.
- The block ignores rd_data when it has not issued a read.

Test Plan:
- Ramp, bank 0 (mem[a] = a): start@bank 0 -> rd_en for 52 cycles. pool_out = 27, 29, ..., 51 at S+5, S+9, ..., S+53. pool_col = 0..12. bank_free = 1 with free_id = 0 at S+53.
- Descending, bank 1 (mem[a] = 200 - a): start@bank 1 -> rd_addr starts at 52. Outputs = 200-52-2k = 148, 146, ..., 124. free_id = 1.
- Ties and extremes: all-255 window -> 255; window {0, 0, 0, 0} -> 0; window {7, 9, 9, 3} -> 9.
- Ping-pong: start bank 0, then start bank 1 at S+10 -> bank 1 reads begin at S+54. 26 contiguous pool_valid groups with no lost strobes. overrun stays 0.
- Overrun: third start while bank 1 is still pending -> overrun = 1 and stays 1 through later banks until rst.
- Reset mid-bank: rst at S+20 -> all outputs 0 the next cycle, no bank_free. A fresh start afterwards produces a full correct bank.
